// File: rtl/lynx_pkg.sv
// Shared types and default constants for the Lynx core clocking blocks.
package lynx_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   localparam int CPU_DIV_DEF    = 8;
   localparam int VID_DIV_DEF    = 4;
   localparam int RST_CYCLES_DEF = 1024;
   localparam int SYS_CLK_HZ     = 32_000_000;

endpackage

// File: rtl/ce_divider.sv
// Free-running divider producing registered one-cycle pulses at count 0 and at mid-period.
// i_half halves the period; it is sampled only at wrap, so periods are never truncated.
module ce_divider #(
   parameter int DIV = 8
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_run,
   input  logic i_half,
   output logic o_pulse,
   output logic o_mid
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST_FULL = W'(DIV - 1);
   localparam logic [W-1:0] LAST_HALF = W'(DIV / 2 - 1);
   localparam logic [W-1:0] MID_FULL  = W'(DIV / 2);
   localparam logic [W-1:0] MID_HALF  = W'(DIV / 4);

   logic [W-1:0] r_cnt;
   logic         r_half;
   logic         r_pulse;
   logic         r_mid;
   logic         w_last;
   logic [W-1:0] w_mid;

   assign w_last  = (r_cnt == (r_half ? LAST_HALF : LAST_FULL));
   assign w_mid   = r_half ? MID_HALF : MID_FULL;
   assign o_pulse = r_pulse;
   assign o_mid   = r_mid;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_half  <= 1'b0;
         r_pulse <= 1'b0;
         r_mid   <= 1'b0;
      end else if (!i_run) begin
         // Idle: hold at 0 and pick up the period mode for the first period after restart.
         r_cnt   <= '0;
         r_half  <= i_half;
         r_pulse <= 1'b0;
         r_mid   <= 1'b0;
      end else begin
         r_pulse <= (r_cnt == '0);
         r_mid   <= (r_cnt == w_mid);
         if (w_last) begin
            r_cnt  <= '0;
            r_half <= i_half;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_enable.sv
// Clock-enable generator and reset sequencer for the Lynx core: lock-qualified reset
// release after RST_CYCLES stable cycles, plus phase-aligned CPU and video enables.
module clock_enable
   import lynx_pkg::*;
#(
   parameter int CPU_DIV    = CPU_DIV_DEF,
   parameter int VID_DIV    = VID_DIV_DEF,
   parameter int RST_CYCLES = RST_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic locked,
   input  logic turbo,
   output logic ce_cpu_p,
   output logic ce_cpu_n,
   output logic ce_vid,
   output logic sys_reset,
   output logic running
);

   localparam int RW = $clog2(RST_CYCLES);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   state_t        r_state;
   state_t        w_next;
   logic [RW-1:0] r_rst_cnt;
   logic          r_sys_reset;
   logic          w_div_run;
   logic          w_vid_mid_unused;

   always_comb begin
      w_next = r_state;
      if (!locked) begin
         w_next = WAIT_LOCK;
      end else begin
         unique case (r_state)
            WAIT_LOCK: w_next = HOLD;
            HOLD:      w_next = (r_rst_cnt == RST_LAST) ? RUN : HOLD;
            RUN:       w_next = RUN;
            default:   w_next = WAIT_LOCK;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= WAIT_LOCK;
         r_rst_cnt   <= '0;
         r_sys_reset <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_sys_reset <= (w_next != RUN);
         // Cleared on any lock loss so a relock always waits the full time; saturates in RUN.
         if (r_state == WAIT_LOCK || w_next == WAIT_LOCK) begin
            r_rst_cnt <= '0;
         end else if (r_rst_cnt != RST_LAST) begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
         end
      end
   end

   // Dividers only run while staying in HOLD/RUN, so no pulse lands in a WAIT_LOCK cycle.
   assign w_div_run = (r_state != WAIT_LOCK) && locked;
   assign sys_reset = r_sys_reset;
   assign running   = ~r_sys_reset;

   ce_divider #(.DIV(CPU_DIV)) u_cpu_div (
      .i_clock (clock),
      .i_reset (reset),
      .i_run   (w_div_run),
      .i_half  (turbo),
      .o_pulse (ce_cpu_p),
      .o_mid   (ce_cpu_n)
   );

   ce_divider #(.DIV(VID_DIV)) u_vid_div (
      .i_clock (clock),
      .i_reset (reset),
      .i_run   (w_div_run),
      .i_half  (1'b0),
      .o_pulse (ce_vid),
      .o_mid   (w_vid_mid_unused)
   );

endmodule

// File: tb/tb_clock_enable.sv
// Bench for clock_enable with RST_CYCLES = 16; observed vector is {sys_reset, running, ce_cpu_p, ce_cpu_n, ce_vid}.
module tb_clock_enable;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic locked = 1'b0;
   logic turbo = 1'b0;
   logic ce_cpu_p, ce_cpu_n, ce_vid, sys_reset, running;
   logic [4:0] obs;

   int n_checks = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [4:0] exp_q[$];

   typedef struct {
      int         at;
      logic [4:0] want;
   } vec_t;
   vec_t tbl[12];

   clock_enable #(.CPU_DIV(8), .VID_DIV(4), .RST_CYCLES(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .locked    (locked),
      .turbo     (turbo),
      .ce_cpu_p  (ce_cpu_p),
      .ce_cpu_n  (ce_cpu_n),
      .ce_vid    (ce_vid),
      .sys_reset (sys_reset),
      .running   (running)
   );

   always #5 clock = ~clock;
   assign obs = {sys_reset, running, ce_cpu_p, ce_cpu_n, ce_vid};

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic check_obs(input string name);
      logic [4:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: expected queue empty, got %b", name, obs);
         return;
      end
      e = exp_q.pop_front();
      if (obs !== e) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got %b want %b (sr,run,p,n,v)", name, cyc, obs, e);
      end
   endtask

   task automatic expect_at(input string name, input int n, input logic [4:0] e);
      run_to(n);
      exp_q.push_back(e);
      check_obs(name);
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic do_reset(input logic lk, input logic tb);
      reset  = 1'b1;
      locked = lk;
      turbo  = tb;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc   = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cp, cn, cv, viol, last_p, last_v;
      logic prev_p, prev_n, prev_v;
      logic ep, en, ev;

      tbl[0]  = '{0,  5'b10000};
      tbl[1]  = '{1,  5'b10000};
      tbl[2]  = '{2,  5'b10101};
      tbl[3]  = '{3,  5'b10000};
      tbl[4]  = '{6,  5'b10011};
      tbl[5]  = '{10, 5'b10101};
      tbl[6]  = '{14, 5'b10011};
      tbl[7]  = '{16, 5'b10000};
      tbl[8]  = '{17, 5'b01000};
      tbl[9]  = '{18, 5'b01101};
      tbl[10] = '{22, 5'b01011};
      tbl[11] = '{23, 5'b01000};

      // Locked from the start: HOLD after edge 1, RUN after edge 17.
      do_reset(1'b1, 1'b0);
      exp_q.push_back(5'b10000);
      check_obs("reset_state");
      for (int i = 0; i < 12; i++) begin
         expect_at($sformatf("startup_%0d", tbl[i].at), tbl[i].at, tbl[i].want);
      end

      // One-cycle lock glitch sampled with rst_cnt = 10.
      do_reset(1'b1, 1'b0);
      run_to(11);
      locked = 1'b0;
      exp_q.push_back(5'b10000);
      check_obs("glitch_low_cycle");
      expect_at("glitch_wait_lock", 12, 5'b10000);
      locked = 1'b1;
      expect_at("relock_hold", 13, 5'b10000);
      expect_at("relock_first_ce", 14, 5'b10101);
      expect_at("relock_last_hold", 28, 5'b10000);
      expect_at("relock_run", 29, 5'b01000);

      // 1000 RUN cycles at normal speed.
      do_reset(1'b1, 1'b0);
      run_to(30);
      cp = 0; cn = 0; cv = 0; viol = 0; last_p = -1; last_v = -1;
      prev_p = 1'b0; prev_n = 1'b0; prev_v = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (ce_cpu_p && ce_cpu_n) viol++;
         if ((ce_cpu_p && prev_p) || (ce_cpu_n && prev_n) || (ce_vid && prev_v)) viol++;
         if (ce_cpu_p) begin
            cp++;
            if (last_p >= 0 && cyc - last_p != 8) viol++;
            last_p = cyc;
         end
         if (ce_cpu_n) begin
            cn++;
            if (last_p < 0 || cyc - last_p != 4) viol++;
         end
         if (ce_vid) begin
            cv++;
            if (last_v >= 0 && cyc - last_v != 4) viol++;
            last_v = cyc;
         end
         prev_p = ce_cpu_p; prev_n = ce_cpu_n; prev_v = ce_vid;
      end
      check_int("count_cpu_p", cp, 125);
      check_int("count_cpu_n", cn, 125);
      check_int("count_vid", cv, 250);
      check_int("spacing_violations", viol, 0);

      // Turbo raised when cpu_cnt = 3: the 8-cycle period completes, then period 4.
      do_reset(1'b1, 1'b0);
      run_to(32);
      for (int c = 33; c <= 55; c++) begin
         ep = (c == 34) || (c == 42) || (c == 46) || (c == 50) || (c == 54);
         en = (c == 38) || (c == 44) || (c == 48) || (c == 52);
         ev = (c % 4 == 2);
         expect_at($sformatf("turbo_c%0d", c), c, {2'b01, ep, en, ev});
         if (c == 36) turbo = 1'b1;
      end

      // Lock loss in RUN, then relock with turbo still set.
      run_to(56);
      locked = 1'b0;
      expect_at("drop_c57", 57, 5'b10000);
      expect_at("drop_c58", 58, 5'b10000);
      expect_at("drop_c59", 59, 5'b10000);
      locked = 1'b1;
      expect_at("rehold_c60", 60, 5'b10000);
      expect_at("rehold_c61", 61, 5'b10101);
      expect_at("rehold_c62", 62, 5'b10000);
      expect_at("rehold_turbo_n", 63, 5'b10010);
      expect_at("rehold_turbo_p", 65, 5'b10101);

      // Asynchronous reset between clock edges while enables are active.
      do_reset(1'b1, 1'b0);
      expect_at("pre_async", 18, 5'b01101);
      #2;
      reset = 1'b1;
      #1;
      exp_q.push_back(5'b10000);
      check_obs("async_reset_immediate");
      @(negedge clock);
      reset = 1'b0;
      cyc   = 0;
      expect_at("after_async_c0", 0, 5'b10000);
      expect_at("after_async_c16", 16, 5'b10000);
      expect_at("after_async_c17", 17, 5'b01000);
      expect_at("after_async_c18", 18, 5'b01101);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
